sprite_layer: RTL
=================

Name: sprite_layer

Overview:
- Positioned, scaled, optionally mirrored single-sprite renderer for the VGA pixel path.
- Replaces full-screen stretched sprite drawing. The sprite sits at a runtime (x,y) with power-of-two scaling and a transparent colour index.
- Position, flip and enable are double-buffered and committed once per frame, so writes never tear.
- Drives an external synchronous sprite ROM and a combinational palette. Emits registered RGB plus a hit flag for a downstream compositor.

Parameters:
- SPRITE_W, 11: sprite width in texels.
- SPRITE_H, 22: sprite height in texels.
- SCALE_LOG2, 2: each texel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels; legal range 0..4.
- ADDR_W, 8: ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H.
- IDX_W, 4: palette index width.
- TRANSPARENT_IDX, 0: ROM index treated as transparent.
- LATCH_Y, 480: DrawY value on which pending settings commit (first blanking line).

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- sprite_x  in  10  pending top-left column.
- sprite_y  in  10  pending top-left row.
- flip_h  in  1  pending horizontal mirror.
- enable  in  1  pending visibility.
- sprite_we  in  1  one-cycle strobe capturing sprite_x/sprite_y/flip_h/enable into pending registers.
- rom_address  out  ADDR_W  to synchronous ROM (1-cycle read latency).
- rom_q  in  IDX_W  ROM data.
- pal_index  out  IDX_W  to combinational palette.
- pal_red, pal_green, pal_blue  in  4 each  palette outputs.
- red, green, blue  out  4 each  registered pixel colour.
- sprite_hit  out  1  registered; 1 = opaque sprite pixel on this output.

Behaviour:
- Reset (async, reset_n=0): red/green/blue=0, sprite_hit=0; pending and active registers: x=0, y=0, flip=0, enable=0; dirty=0; pipeline valid bits=0. rom_address is combinational; reset does not force it.
- Pending capture: sprite_we=1 at an edge loads the pending registers and sets dirty=1.
- Commit: at the edge where DrawX==0 && DrawY==LATCH_Y && dirty==1, active registers take the pending values and dirty clears.
- Same-cycle sprite_we and commit: active takes the pre-edge pending values; the new values land in pending; dirty stays 1, so the new values commit next frame.
- Stage 0 (cycle t, combinational from DrawX/DrawY and active regs):
  - lx = DrawX - act_x and ly = DrawY - act_y, 11-bit unsigned subtract.
  - in_box = act_en && DrawX >= act_x && DrawY >= act_y && lx < (SPRITE_W<<SCALE_LOG2) && ly < (SPRITE_H<<SCALE_LOG2).
  - No wrap-around: a sprite extending past column 639 / row 479 is clipped, never wrapped.
  - col = lx>>SCALE_LOG2, or SPRITE_W-1-(lx>>SCALE_LOG2) when act_flip.
  - row = ly>>SCALE_LOG2.
  - rom_address = row*SPRITE_W + col, truncated to ADDR_W. Only defined when in_box; 0 otherwise.
- Stage 1 (t+1): registered v1 = in_box && blank. pal_index = rom_q.
- Stage 2 (registered at end of t+1, visible during t+2):
  - if v1 && rom_q != TRANSPARENT_IDX: red/green/blue = pal_*, sprite_hit = 1;
  - else: red/green/blue = 0, sprite_hit = 0.
- Latency: exactly 2 vga_clk cycles from DrawX/DrawY/blank to output, identical for every pixel.
- Commit occurs in blanking, so no visible line ever mixes old and new position.
- reset_n asserted mid-line: outputs drop to 0 immediately. After release, the first two output cycles are 0/miss regardless of input, because the pipeline valid bits are cleared.
- act_x + sprite extent beyond 1023 is handled purely by the compare; no overflow artefacts.

Test Plan:
- Reset, sprite_we with x=100, y=50, en=1, then run to DrawY=480/DrawX=0 -> active x=100 takes effect from the next frame. The prior frame shows no hit anywhere.
- SCALE_LOG2=2, x=100, y=50; DrawX=100..143, DrawY=50 -> rom_address 0..10, each held 4 pixels. DrawY=54 -> address 11. DrawX=144 -> sprite_hit=0. Outputs appear 2 cycles later.
- flip_h=1 committed; DrawX=100, DrawY=50 -> rom_address=10. DrawX=143 -> rom_address=0.
- ROM returns TRANSPARENT_IDX inside the box -> RGB=0, sprite_hit=0. Index 5 with palette (F,8,2) -> RGB=F,8,2 and sprite_hit=1 two cycles after the pixel. blank=0 inside the box -> sprite_hit=0.
- sprite_we pulse coinciding with the commit edge -> the old pending value commits, dirty stays 1, and the new value commits exactly one frame later.
- x=620, y=470 -> hits only for DrawX 620..639 and DrawY 470..479. Column 0 and row 0 never hit (no wrap). Assert reset_n mid-hit -> RGB/sprite_hit=0 asynchronously.

Source files
------------

// File: rtl/sprite_layer.sv
// Single-sprite renderer for the VGA pixel path: positioned, power-of-two scaled,
// optionally mirrored, with per-frame double-buffered settings and a 2-cycle pipeline.
module sprite_layer #(
    parameter int SPRITE_W        = 11,
    parameter int SPRITE_H        = 22,
    parameter int SCALE_LOG2      = 2,
    parameter int ADDR_W          = 8,
    parameter int IDX_W           = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int LATCH_Y         = 480
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_h,
    input  logic              enable,
    input  logic              sprite_we,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit
);

    localparam logic [10:0] BOX_W = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPRITE_H << SCALE_LOG2);

    logic [9:0]  r_pend_x, r_pend_y, r_act_x, r_act_y;
    logic        r_pend_flip, r_pend_en, r_act_flip, r_act_en;
    logic        r_dirty;
    logic        r_v1;

    logic        w_commit;
    logic [10:0] w_lx, w_ly, w_tx, w_col, w_row;
    logic        w_in_box;
    logic [ADDR_W-1:0] w_lin;

    // Commit lands on the first blanking line so no visible line mixes old and new settings.
    assign w_commit = (DrawX == 10'd0) && (DrawY == 10'(LATCH_Y)) && r_dirty;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_flip <= 1'b0;
            r_pend_en   <= 1'b0;
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_act_flip  <= 1'b0;
            r_act_en    <= 1'b0;
            r_dirty     <= 1'b0;
        end else begin
            if (sprite_we) begin
                r_pend_x    <= sprite_x;
                r_pend_y    <= sprite_y;
                r_pend_flip <= flip_h;
                r_pend_en   <= enable;
            end
            if (w_commit) begin
                r_act_x    <= r_pend_x;
                r_act_y    <= r_pend_y;
                r_act_flip <= r_pend_flip;
                r_act_en   <= r_pend_en;
            end
            if (sprite_we)
                r_dirty <= 1'b1;
            else if (w_commit)
                r_dirty <= 1'b0;
        end
    end

    // The explicit >= compares make off-screen extents clip instead of wrapping.
    assign w_lx     = {1'b0, DrawX} - {1'b0, r_act_x};
    assign w_ly     = {1'b0, DrawY} - {1'b0, r_act_y};
    assign w_in_box = r_act_en && (DrawX >= r_act_x) && (DrawY >= r_act_y)
                      && (w_lx < BOX_W) && (w_ly < BOX_H);
    assign w_tx     = w_lx >> SCALE_LOG2;
    assign w_col    = r_act_flip ? (11'(SPRITE_W - 1) - w_tx) : w_tx;
    assign w_row    = w_ly >> SCALE_LOG2;
    assign w_lin    = ADDR_W'(w_row * 11'(SPRITE_W)) + ADDR_W'(w_col);

    assign rom_address = w_in_box ? w_lin : '0;
    assign pal_index   = rom_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1       <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            sprite_hit <= 1'b0;
        end else begin
            r_v1 <= w_in_box && blank;
            if (r_v1 && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
                red        <= pal_red;
                green      <= pal_green;
                blue       <= pal_blue;
                sprite_hit <= 1'b1;
            end else begin
                red        <= '0;
                green      <= '0;
                blue       <= '0;
                sprite_hit <= 1'b0;
            end
        end
    end

endmodule
